// File: rtl/serial_sub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : serial_sub                                                        |
// | Brief   : Bit-serial ripple-borrow subtractor, LSB first, one bit per clock |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module serial_sub #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bi,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] d,
   output logic         bo,
   output logic         zero
);

   localparam int CW = (W > 2) ? $clog2(W) : 1;
   localparam logic [CW-1:0] c_last = CW'(W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic            r_brw;
   logic [CW-1:0]   r_cnt;
   logic [W-2:0]    r_acc;
   logic [W-1:0]    r_d;
   logic            r_bo;
   logic            r_busy;
   logic            r_done;

   logic            w_dbit;
   logic            w_bnext;
   logic [W-1:0]    w_dnext;

   assign w_dbit  = r_a[0] ^ r_b[0] ^ r_brw;
   assign w_bnext = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);
   // Difference bits enter at the top so bit 0 lands in place after W shifts.
   assign w_dnext = {w_dbit, r_acc};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_brw   <= 1'b0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_d     <= '0;
         r_bo    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_brw   <= bi;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_brw <= w_bnext;
               r_acc <= w_dnext[W-1:1];
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == c_last) begin
                  r_d     <= w_dnext;
                  r_bo    <= w_bnext;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_brw   <= bi;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign d    = r_d;
   assign bo   = r_bo;
   assign zero = ~|r_d;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_serial_sub                                                     |
// | Brief   : Directed and exhaustive self-checking bench for serial_sub (W=4)  |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_serial_sub;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bi;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bo;
   logic         zero;

   int           n_checks;
   int           n_errors;
   logic [W-1:0] r_prev_d;

   serial_sub #(.W(W)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bi    (bi),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bo    (bo),
      .zero  (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full transaction from IDLE: accept, W RUN cycles, one-cycle done, back to IDLE.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi,
                         input logic [W-1:0] ed, input logic ebo, input logic ezero);
      a = ta; b = tb; bi = tbi; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < W; k++) begin
         check("run_busy", busy, 1'b1);
         check("run_no_done", done, 1'b0);
         check("run_d_hold", d, r_prev_d);
         a = ~ta; b = ~tb;
         step();
      end
      check("done", done, 1'b1);
      check("done_busy", busy, 1'b0);
      check("d", d, ed);
      check("bo", bo, ebo);
      check("zero", zero, ezero);
      r_prev_d = ed;
      step();
      check("done_pulse", done, 1'b0);
      check("d_stable", d, ed);
   endtask

   initial begin
      logic [W:0] ref_v;
      n_checks = 0;
      n_errors = 0;
      r_prev_d = '0;
      rst = 1'b1; start = 1'b1; a = 4'd9; b = 4'd3; bi = 1'b0;
      step();
      step();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_d", d, 4'd0);
      check("rst_bo", bo, 1'b0);
      check("rst_zero", zero, 1'b1);
      rst = 1'b0; start = 1'b0;
      step();

      run_op(4'd9, 4'd3, 1'b0, 4'd6,  1'b0, 1'b0);
      run_op(4'd3, 4'd9, 1'b0, 4'd10, 1'b1, 1'b0);
      run_op(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0);
      run_op(4'd5, 4'd5, 1'b0, 4'd0,  1'b0, 1'b1);

      // start held through RUN with operands changing, then back-to-back.
      a = 4'd12; b = 4'd4; bi = 1'b0; start = 1'b1;
      step();
      for (int k = 0; k < W; k++) begin
         check("hold_busy", busy, 1'b1);
         check("hold_no_done", done, 1'b0);
         a = 4'(k * 5 + 1); b = 4'(k * 3 + 7);
         step();
      end
      check("hold_done", done, 1'b1);
      check("hold_d", d, 4'd8);
      check("hold_bo", bo, 1'b0);
      a = 4'd7; b = 4'd8; bi = 1'b0;
      step();
      start = 1'b0;
      check("b2b_busy", busy, 1'b1);
      check("b2b_no_done", done, 1'b0);
      check("b2b_d_hold", d, 4'd8);
      for (int k = 0; k < W - 1; k++) begin
         step();
         check("b2b_wait", done, 1'b0);
      end
      step();
      check("b2b_done", done, 1'b1);
      check("b2b_d", d, 4'd15);
      check("b2b_bo", bo, 1'b1);
      step();
      check("b2b_idle", busy, 1'b0);

      // Reset during the second RUN cycle discards the operation.
      a = 4'd9; b = 4'd3; bi = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      check("mid_busy", busy, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_d", d, 4'd0);
      check("mid_rst_bo", bo, 1'b0);
      check("mid_rst_zero", zero, 1'b1);
      for (int k = 0; k < W + 2; k++) begin
         step();
         check("mid_no_done", done, 1'b0);
      end
      r_prev_d = '0;

      // Exhaustive sweep against an arithmetic reference.
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               ref_v = {1'b0, 4'(ia)} - {1'b0, 4'(ib)} - 5'(ic);
               run_op(4'(ia), 4'(ib), 1'(ic), ref_v[W-1:0], ref_v[W], (ref_v[W-1:0] == '0));
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation timeout");
   end

endmodule
`default_nettype wire
